// File: rtl/ysyx_23060061_mem_responder.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | Module  : ysyx_23060061_mem_responder                                        |
// | Brief   : Valid/ready memory target: fixed or randomized access latency,     |
// |           byte-masked word writes. Optional: YSYX_23060061_MEM_RAND_DELAY_EN |
// | Revision: 1.0 - initial release                                              |
// +------------------------------------------------------------------------------+
module ysyx_23060061_mem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam logic [32:0] SPAN   = 33'(DEPTH) << 2;
  localparam logic [4:0]  LAT_M1 = 5'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        wen_q, wen_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        mem_we;
  logic [4:0]  cnt_load;

  logic [31:0] mem [DEPTH];

  logic [31:0]      off;
  logic             acc_err;
  logic [IDX_W-1:0] idx;

  assign off     = addr_q - BASE;
  assign acc_err = (addr_q[1:0] != 2'b00) || (addr_q < BASE) || ({1'b0, off} >= SPAN);
  assign idx     = off[IDX_W+1:2];

`ifdef YSYX_23060061_MEM_RAND_DELAY_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Fibonacci taps 8,6,5,4 map to bits 7,5,4,3
  assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign cnt_load = LAT_M1 + {3'b000, lfsr_q[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= 8'hA5;
    else      lfsr_q <= lfsr_d;
  end
`else
  assign cnt_load = LAT_M1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wen_d   = req_wen;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wmask_d = req_wmask;
          cnt_d   = cnt_load;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 5'd0) begin
          cnt_d = cnt_q - 5'd1;
        end else begin
          state_d = RESP;
          err_d   = acc_err;
          rdata_d = (acc_err || wen_q) ? 32'h0 : mem[idx];
          mem_we  = wen_q && !acc_err;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = 32'h0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      wen_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wmask_q <= 4'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is deliberately not reset; mem_we is gated by state_q, so a reset in WAIT drops the write
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060061_mem_responder.sv
`default_nettype none
// Directed bench for ysyx_23060061_mem_responder with a response scoreboard.
module tb_ysyx_23060061_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  ysyx_23060061_mem_responder #(
    .DEPTH  (1024),
    .BASE   (32'h8000_0000),
    .LATENCY(LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_wen  (req_wen),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_wmask(req_wmask),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          fails   = 0;
  int          last_lat;
  logic [63:0] lat_seen = 64'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Entered and left at #1 after a rising edge with the DUT idle.
  task automatic xact(input string tag, input logic wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] wmask,
                      input logic [31:0] exp_rdata, input logic exp_err, input int bp);
    exp_t        e;
    int          lat;
    logic [31:0] held;
    sb.push_back('{rdata: exp_rdata, err: exp_err});
    chk({tag, "/req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = wmask;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    last_lat = lat;
    if (lat < 64) lat_seen[lat] = 1'b1;
`ifdef YSYX_23060061_MEM_RAND_DELAY_EN
    chk({tag, "/lat_in_range"}, 32'(lat >= LAT && lat <= LAT + 3), 32'd1);
`else
    chk({tag, "/latency"}, 32'(lat), 32'(LAT));
`endif
    e = sb.pop_front();
    chk({tag, "/rdata"}, rsp_rdata, e.rdata);
    chk({tag, "/err"}, 32'(rsp_err), 32'(e.err));
    held = rsp_rdata;
    for (int i = 0; i < bp; i++) begin
      // A competing write while the response is stalled must be ignored
      req_valid = 1'b1;
      req_wen   = 1'b1;
      req_addr  = 32'h8000_0004;
      req_wdata = 32'h0BAD_F00D;
      req_wmask = 4'hF;
      @(posedge clk); #1;
      chk({tag, "/bp_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "/bp_rdata"}, rsp_rdata, held);
      chk({tag, "/bp_req_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk({tag, "/post_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "/post_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "/post_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "/post_err"}, 32'(rsp_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    req_wen   = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_wmask = 4'h0;
    rsp_ready = 1'b0;
    #12;
    chk("reset/req_ready", 32'(req_ready), 32'd1);
    chk("reset/rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset/rsp_rdata", rsp_rdata, 32'h0);
    chk("reset/rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    xact("wr_full",   1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 0);
    xact("rd_full",   1'b0, 32'h8000_0004, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 0);
    xact("wr_lane1",  1'b1, 32'h8000_0004, 32'h1122_3344, 4'b0010, 32'h0, 1'b0, 0);
    xact("rd_lane1",  1'b0, 32'h8000_0004, 32'h0,         4'h0, 32'hDEAD_33EF, 1'b0, 0);
    xact("rd_misal",  1'b0, 32'h8000_0002, 32'h0,         4'h0, 32'h0, 1'b1, 0);
    xact("wr_high",   1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 0);
    xact("rd_low",    1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0, 1'b1, 0);
    xact("wr_nomask", 1'b1, 32'h8000_0004, 32'h5555_5555, 4'h0, 32'h0, 1'b0, 0);
    xact("rd_bp",     1'b0, 32'h8000_0004, 32'h0,         4'h0, 32'hDEAD_33EF, 1'b0, 5);
    xact("rd_after",  1'b0, 32'h8000_0004, 32'h0,         4'h0, 32'hDEAD_33EF, 1'b0, 0);
    xact("wr_last",   1'b1, 32'h8000_0FFC, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 0);
    xact("rd_last",   1'b0, 32'h8000_0FFC, 32'h0,         4'h0, 32'h1234_5678, 1'b0, 0);
    xact("wr_zero8",  1'b1, 32'h8000_0008, 32'h0,         4'hF, 32'h0, 1'b0, 0);

    // Reset while the write sits in WAIT
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_addr  = 32'h8000_0008;
    req_wdata = 32'hCAFE_F00D;
    req_wmask = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_wait/in_wait", 32'(req_ready), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("rst_wait/req_ready", 32'(req_ready), 32'd1);
    chk("rst_wait/rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_wait/rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_wait/rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    xact("rd_rst8",   1'b0, 32'h8000_0008, 32'h0,         4'h0, 32'h0, 1'b0, 0);
    xact("rd_keep4",  1'b0, 32'h8000_0004, 32'h0,         4'h0, 32'hDEAD_33EF, 1'b0, 0);

    lat_seen = 64'h0;
    for (int k = 0; k < 32; k++) begin
      xact("rd_b2b", 1'b0, 32'h8000_0004, 32'h0, 4'h0, 32'hDEAD_33EF, 1'b0, 0);
    end
`ifdef YSYX_23060061_MEM_RAND_DELAY_EN
    chk("b2b/distinct_lat", 32'($countones(lat_seen) >= 2), 32'd1);
`else
    chk("b2b/lat_set", lat_seen[31:0], 32'h1 << LAT);
`endif
    chk("sb/empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
`default_nettype wire
